// File: rtl/debug_mem_dumper_if.sv
// Bus between the memory dumper, the MEM stage debug read port and the UART tx.
// master = dumper side, slave = MEM stage / UART / command decoder side.
interface debug_mem_dumper_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 7
);
    // Handshake: start is a one-cycle request honoured only when idle. tx_start is
    // a one-cycle pulse qualifying tx_data; the sink returns a one-cycle tx_done once
    // the byte has left, and tx_start never repeats before that tx_done.
    logic               start;
    logic               only_dirty;
    logic [NB_ADDR-1:0] addr_mem_debug_unit;
    logic               ctrl_addr_debug_mem;
    logic               ctrl_wr_debug_mem;
    logic [NB_DATA-1:0] data_mem_debug_unit;
    logic               bit_sucio;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_done;
    logic               busy;
    logic               done;
    logic [NB_ADDR:0]   words_sent;

    modport master (
        input  start, only_dirty, data_mem_debug_unit, bit_sucio, tx_done,
        output addr_mem_debug_unit, ctrl_addr_debug_mem, ctrl_wr_debug_mem,
        output tx_data, tx_start, busy, done, words_sent
    );

    modport slave (
        output start, only_dirty, data_mem_debug_unit, bit_sucio, tx_done,
        input  addr_mem_debug_unit, ctrl_addr_debug_mem, ctrl_wr_debug_mem,
        input  tx_data, tx_start, busy, done, words_sent
    );
endinterface

// File: rtl/debug_mem_dumper.sv
// Walks data memory through the MEM stage debug port and streams every word,
// LSB byte first, to the UART transmitter; optionally skips never-written words.
module debug_mem_dumper #(
    parameter int NB_DATA     = 32,
    parameter int NB_ADDR     = 7,
    parameter int N_WORDS     = 128,
    parameter int MEM_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    debug_mem_dumper_if.master  bus,
    output logic [2:0]          state_dbg
);
    localparam int NB_BYTES = NB_DATA / 8;
    localparam int IDX_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_WORDS - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NB_BYTES - 1);
    localparam logic [CNT_W-1:0]   LAST_WAIT = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_SAMPLE  = 3'd2,
        S_SEND    = 3'd3,
        S_WAIT_TX = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t             state;
    logic               only_dirty_q;
    logic               sel;
    logic [CNT_W-1:0]   wait_cnt;
    logic [IDX_W-1:0]   idx;
    logic [NB_DATA-1:0] shreg;
    logic [NB_DATA-1:0] shreg_next;

    // Both debug selects share one register so they can never disagree.
    assign bus.ctrl_addr_debug_mem = sel;
    assign bus.ctrl_wr_debug_mem   = sel;
    assign shreg_next              = shreg >> 8;
    assign state_dbg               = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= S_IDLE;
            only_dirty_q            <= 1'b0;
            sel                     <= 1'b0;
            wait_cnt                <= '0;
            idx                     <= '0;
            shreg                   <= '0;
            bus.addr_mem_debug_unit <= '0;
            bus.tx_data             <= '0;
            bus.tx_start            <= 1'b0;
            bus.busy                <= 1'b0;
            bus.done                <= 1'b0;
            bus.words_sent          <= '0;
        end else begin
            bus.tx_start <= 1'b0;
            bus.done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        only_dirty_q            <= bus.only_dirty;
                        bus.addr_mem_debug_unit <= '0;
                        bus.words_sent          <= '0;
                        bus.busy                <= 1'b1;
                        sel                     <= 1'b1;
                        wait_cnt                <= '0;
                        state                   <= S_READ;
                    end
                end
                S_READ: begin
                    if (wait_cnt == LAST_WAIT) begin
                        wait_cnt <= '0;
                        state    <= S_SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    shreg <= bus.data_mem_debug_unit;
                    if (only_dirty_q && !bus.bit_sucio) begin
                        state <= S_NEXT;
                    end else begin
                        idx          <= '0;
                        bus.tx_data  <= bus.data_mem_debug_unit[7:0];
                        bus.tx_start <= 1'b1;
                        state        <= S_SEND;
                    end
                end
                S_SEND: begin
                    state <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (bus.tx_done) begin
                        if (idx == LAST_IDX) begin
                            bus.words_sent <= bus.words_sent + (NB_ADDR + 1)'(1);
                            state          <= S_NEXT;
                        end else begin
                            // Next byte is loaded together with its start pulse.
                            idx          <= idx + IDX_W'(1);
                            shreg        <= shreg_next;
                            bus.tx_data  <= shreg_next[7:0];
                            bus.tx_start <= 1'b1;
                            state        <= S_SEND;
                        end
                    end
                end
                S_NEXT: begin
                    if (bus.addr_mem_debug_unit == LAST_ADDR) begin
                        bus.done                <= 1'b1;
                        bus.busy                <= 1'b0;
                        sel                     <= 1'b0;
                        bus.addr_mem_debug_unit <= '0;
                        state                   <= S_DONE;
                    end else begin
                        bus.addr_mem_debug_unit <= bus.addr_mem_debug_unit + NB_ADDR'(1);
                        state                   <= S_READ;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_debug_mem_dumper.sv
// Bench for debug_mem_dumper: three instances (latency 2 / 3, 128 / 8 / 1 words)
// share a memory model and a fake UART; a queue-based model predicts the byte stream.
module tb_debug_mem_dumper;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_mem_dumper_if #(.NB_DATA(32), .NB_ADDR(7)) bus0 ();
    debug_mem_dumper_if #(.NB_DATA(32), .NB_ADDR(7)) bus1 ();
    debug_mem_dumper_if #(.NB_DATA(32), .NB_ADDR(7)) bus2 ();
    logic [2:0] st0, st1, st2;

    debug_mem_dumper #(.NB_DATA(32), .NB_ADDR(7), .N_WORDS(128), .MEM_LATENCY(2))
        dut0 (.clk(clk), .rst(rst), .bus(bus0), .state_dbg(st0));
    debug_mem_dumper #(.NB_DATA(32), .NB_ADDR(7), .N_WORDS(8), .MEM_LATENCY(3))
        dut1 (.clk(clk), .rst(rst), .bus(bus1), .state_dbg(st1));
    debug_mem_dumper #(.NB_DATA(32), .NB_ADDR(7), .N_WORDS(1), .MEM_LATENCY(2))
        dut2 (.clk(clk), .rst(rst), .bus(bus2), .state_dbg(st2));

    int lat [3] = '{2, 3, 2};
    int nw  [3] = '{128, 8, 1};

    // Stimulus side
    logic start_v [3];
    logic od_v    [3];
    logic tx_done_v [3];
    assign bus0.start = start_v[0];  assign bus1.start = start_v[1];  assign bus2.start = start_v[2];
    assign bus0.only_dirty = od_v[0]; assign bus1.only_dirty = od_v[1]; assign bus2.only_dirty = od_v[2];
    assign bus0.tx_done = tx_done_v[0]; assign bus1.tx_done = tx_done_v[1]; assign bus2.tx_done = tx_done_v[2];

    // Observed side
    logic [2:0] txs_v, busy_v, done_v, sel_v;
    logic [7:0] txd_v  [3];
    logic [6:0] addr_v [3];
    logic [7:0] ws_v   [3];
    assign txs_v  = {bus2.tx_start, bus1.tx_start, bus0.tx_start};
    assign busy_v = {bus2.busy, bus1.busy, bus0.busy};
    assign done_v = {bus2.done, bus1.done, bus0.done};
    assign sel_v  = {bus2.ctrl_addr_debug_mem & bus2.ctrl_wr_debug_mem,
                     bus1.ctrl_addr_debug_mem & bus1.ctrl_wr_debug_mem,
                     bus0.ctrl_addr_debug_mem & bus0.ctrl_wr_debug_mem};
    assign txd_v[0] = bus0.tx_data;  assign txd_v[1] = bus1.tx_data;  assign txd_v[2] = bus2.tx_data;
    assign addr_v[0] = bus0.addr_mem_debug_unit;
    assign addr_v[1] = bus1.addr_mem_debug_unit;
    assign addr_v[2] = bus2.addr_mem_debug_unit;
    assign ws_v[0] = bus0.words_sent; assign ws_v[1] = bus1.words_sent; assign ws_v[2] = bus2.words_sent;

    // Memory model: contents + dirty flags, and an address/select delay line per port
    logic [31:0] mem   [128];
    logic        dirty [128];
    logic [6:0]  ap [3][3];
    logic        sp [3][3];
    localparam logic [31:0] UNSELECTED = 32'hBAD0_BAD0;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 2; i > 0; i--) begin
                ap[k][i] <= ap[k][i-1];
                sp[k][i] <= sp[k][i-1];
            end
            ap[k][0] <= addr_v[k];
            sp[k][0] <= sel_v[k];
        end
    end

    assign bus0.data_mem_debug_unit = sp[0][1] ? mem[ap[0][1]] : UNSELECTED;
    assign bus0.bit_sucio           = sp[0][1] & dirty[ap[0][1]];
    assign bus1.data_mem_debug_unit = sp[1][2] ? mem[ap[1][2]] : UNSELECTED;
    assign bus1.bit_sucio           = sp[1][2] & dirty[ap[1][2]];
    assign bus2.data_mem_debug_unit = sp[2][1] ? mem[ap[2][1]] : UNSELECTED;
    assign bus2.bit_sucio           = sp[2][1] & dirty[ap[2][1]];

    // Fake UART + run monitor
    int tx_delay [3];
    int pend [3];
    int cnt  [3];
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int busy_cyc, done_cnt, sel_drop, addr_err, dbl_start;

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                pend[k]      = 0;
                tx_done_v[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                tx_done_v[k] = 1'b0;
                if (pend[k] != 0) begin
                    cnt[k] = cnt[k] - 1;
                    if (cnt[k] == 0) begin
                        tx_done_v[k] = 1'b1;
                        pend[k]      = 0;
                    end
                end
                if (txs_v[k]) begin
                    got_q.push_back(txd_v[k]);
                    if (pend[k] != 0) dbl_start++;
                    pend[k] = 1;
                    cnt[k]  = tx_delay[k];
                end
                if (busy_v[k]) begin
                    busy_cyc++;
                    if (!sel_v[k]) sel_drop++;
                    if (int'(addr_v[k]) >= nw[k]) addr_err++;
                end
                if (done_v[k]) done_cnt++;
            end
        end
    end

    // Scoreboard
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            od_v[k]    = 1'b0;
        end
        for (int i = 0; i < 128; i++) dirty[i] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input int k, input string tag);
        check_eq($sformatf("%s[%0d] addr", tag, k), 32'(addr_v[k]), 0);
        check_eq($sformatf("%s[%0d] sel", tag, k), 32'(sel_v[k]), 0);
        check_eq($sformatf("%s[%0d] tx_data", tag, k), 32'(txd_v[k]), 0);
        check_eq($sformatf("%s[%0d] tx_start", tag, k), 32'(txs_v[k]), 0);
        check_eq($sformatf("%s[%0d] busy", tag, k), 32'(busy_v[k]), 0);
        check_eq($sformatf("%s[%0d] done", tag, k), 32'(done_v[k]), 0);
        check_eq($sformatf("%s[%0d] words_sent", tag, k), 32'(ws_v[k]), 0);
    endtask

    task automatic mem_write(input int a, input logic [31:0] d);
        mem[a]   = d;
        dirty[a] = 1'b1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
    endtask

    // Reference: every selected word contributes its bytes LSB first and a fixed cost.
    task automatic build_model(input int k, input bit od, input int d,
                               output int words, output int cycles);
        exp_q.delete();
        words  = 0;
        cycles = 0;
        for (int w = 0; w < nw[k]; w++) begin
            if (!od || dirty[w]) begin
                for (int b = 0; b < 4; b++) exp_q.push_back(mem[w][8*b +: 8]);
                words++;
                cycles += lat[k] + 2 + 4 * (1 + d);
            end else begin
                cycles += lat[k] + 2;
            end
        end
    endtask

    task automatic start_run(input int k, input bit od, input int d);
        got_q.delete();
        busy_cyc = 0; done_cnt = 0; sel_drop = 0; addr_err = 0; dbl_start = 0;
        tx_delay[k] = d;
        od_v[k]    = od;
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        od_v[k]    = 1'($urandom_range(0, 1));
    endtask

    task automatic run_dump(input int k, input bit od, input int d,
                            input int restart_word, input string tag);
        int exp_words, exp_cycles, cyc, e0;
        bit seen, restarted;
        build_model(k, od, d, exp_words, exp_cycles);
        start_run(k, od, d);
        seen = 0; restarted = 0; cyc = 0;
        while (!seen && cyc < exp_cycles + 200) begin
            @(negedge clk);
            cyc++;
            start_v[k] = 1'b0;
            if (done_v[k]) seen = 1;
            if (restart_word >= 0 && !restarted && got_q.size() == restart_word * 4 + 1) begin
                start_v[k] = 1'b1;
                restarted  = 1;
            end
        end
        start_v[k] = 1'b0;
        repeat (20) @(negedge clk);
        check_eq({tag, " done_seen"}, 32'(seen), 1);
        check_eq({tag, " byte_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            e0 = n_errors;
            check_eq($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            if (n_errors != e0) break;
        end
        check_eq({tag, " words_sent"}, 32'(ws_v[k]), exp_words);
        check_eq({tag, " done_pulses"}, done_cnt, 1);
        check_eq({tag, " busy_cycles"}, busy_cyc, exp_cycles);
        check_eq({tag, " select_drops"}, sel_drop, 0);
        check_eq({tag, " addr_range"}, addr_err, 0);
        check_eq({tag, " tx_start_overlap"}, dbl_start, 0);
        check_eq({tag, " idle_after"}, 32'(busy_v[k]), 0);
    endtask

    task automatic reset_mid_run();
        int cyc, n_before;
        fill_random();
        mem[5] = 32'hA1B2_C3D4;
        start_run(0, 1'b0, 5);
        cyc = 0;
        while (got_q.size() < 23 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rst_mid reached_w5b2", got_q.size(), 23);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_outputs_zero(0, "rst_mid async");
        for (int i = 0; i < 128; i++) dirty[i] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        n_before = got_q.size();
        repeat (40) @(negedge clk);
        check_eq("rst_mid no_tx_after", got_q.size(), n_before);
        check_eq("rst_mid busy_after", 32'(busy_v[0]), 0);
        run_dump(0, 1'b0, $urandom_range(1, 4), -1, "rst_mid rerun");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            start_v[k]  = 1'b0;
            od_v[k]     = 1'b0;
            tx_delay[k] = 5;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_outputs_zero(k, "reset");
        #2 rst = 1'b0;
        @(negedge clk);

        // Known pattern, with a start pulse re-issued mid run
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
        run_dump(0, 1'b0, 5, 10, "full");

        // Dirty-only: two written words
        do_reset();
        mem_write(3, 32'hDEAD_BEEF);
        mem_write(100, 32'h0000_00A5);
        run_dump(0, 1'b1, $urandom_range(1, 6), -1, "dirty2");

        reset_mid_run();

        // Latency 3 with a slow transmitter
        do_reset();
        fill_random();
        for (int i = 0; i < 3; i++) mem_write($urandom_range(0, 7), $urandom);
        run_dump(1, 1'b0, 50, -1, "lat3 all");
        run_dump(1, 1'b1, 50, -1, "lat3 dirty");

        // Single-word instance, clean and dirty word 0
        do_reset();
        fill_random();
        run_dump(2, 1'b0, $urandom_range(1, 5), -1, "one all");
        run_dump(2, 1'b1, $urandom_range(1, 5), -1, "one clean");
        mem_write(0, $urandom);
        run_dump(2, 1'b1, $urandom_range(1, 5), -1, "one dirty");

        // Random rounds on the full-size instance
        for (int r = 0; r < 4; r++) begin
            do_reset();
            fill_random();
            for (int n = $urandom_range(0, 12); n > 0; n--) mem_write($urandom_range(0, 127), $urandom);
            run_dump(0, 1'($urandom_range(0, 1)), $urandom_range(1, 4), -1, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/debug_mem_dumper.md
Name: debug_mem_dumper

Overview:
- Debug-unit engine that reads the data memory word by word through the MEM stage's debug port and streams each word out as bytes to the UART transmitter.
- Started by the debug unit's command decoder.
- While running, it owns the MEM stage's debug address select and the debug read select.
- Optional dirty-only mode skips words never written since reset.

Parameters:
NB_DATA, 32, data memory word width (multiple of 8)
NB_ADDR, 7, data memory address width (word addressed)
N_WORDS, 128, words dumped per run (1..2^NB_ADDR)
MEM_LATENCY, 2, clocks from address valid to registered data and dirty flag valid at this block's inputs

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous active-high reset
i_start  in  1  one-cycle pulse; begin dump, ignored unless idle
i_only_dirty  in  1  sampled at start; 1 = transmit only words whose dirty flag is 1
o_addr_mem_debug_unit  out  NB_ADDR  word address presented to MEM stage
o_ctrl_addr_debug_mem  out  1  1 = MEM stage uses o_addr_mem_debug_unit
o_ctrl_wr_debug_mem  out  1  1 = MEM stage forces signed debug read control
i_data_mem_debug_unit  in  NB_DATA  registered read data from MEM stage
i_bit_sucio  in  1  registered dirty flag, aligned with data
o_tx_data  out  8  byte to UART tx
o_tx_start  out  1  one-cycle pulse; o_tx_data valid this cycle
i_tx_done  in  1  one-cycle pulse; tx finished current byte
o_busy  out  1  high from accepted start until done
o_done  out  1  one-cycle pulse at end of run
o_words_sent  out  NB_ADDR+1  words transmitted in last/current run

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0: address, ctrl selects, tx_data, tx_start, busy, done, words_sent. Internal counters cleared. An in-flight byte is abandoned; no further tx_start is issued.
- IDLE: selects low. On i_start: latch i_only_dirty, address=0, words_sent=0, busy=1, go to READ.
- READ:
  - Both ctrl selects=1 and address stable from READ through SAMPLE.
  - Wait counter counts MEM_LATENCY cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - Capture data word into shift register and capture dirty flag.
  - If only_dirty=1 and dirty=0 → NEXT.
  - Otherwise byte index=0 → SEND.
- SEND (1 cycle):
  - o_tx_data = word bits [8*idx+7:8*idx]; bytes are sent LSB first.
  - o_tx_start=1 for exactly this cycle → WAIT_TX.
- WAIT_TX:
  - Hold o_tx_data.
  - On i_tx_done: if idx=NB_DATA/8-1, words_sent+=1 → NEXT; else idx+=1 → SEND.
  - i_tx_done outside WAIT_TX is ignored.
- NEXT (1 cycle):
  - If address=N_WORDS-1 → DONE.
  - Otherwise address+=1 → READ.
  - The address never wraps past N_WORDS-1, and there is no modular wrap at 2^NB_ADDR.
- DONE (1 cycle): o_done=1, busy=0, selects=0, address returns to 0 → IDLE. words_sent holds until the next start.
- Selects stay high continuously from leaving IDLE until DONE, including during tx waits. The pipeline is frozen by the debug unit during a dump, so this is required.
- i_start while busy: ignored, with no restart.
- i_start coincident with reset deassert edge: ignored.
- Throughput: a full word costs MEM_LATENCY+1 cycles + 4×(1+tx time) + 1 cycle. A skipped word costs MEM_LATENCY+2 cycles.
- o_tx_start is never asserted twice without an intervening i_tx_done.

Test Plan:
- Preload mem[0..127]=32'h1000_0000+i; start with only_dirty=0; fake tx returns done 5 cycles after start.
  → 512 bytes; first four 00,00,00,10; last four 7F,00,00,10; words_sent=128; one done pulse.
- Writes to addr 3 (32'hDEAD_BEEF) and addr 100 (32'h0000_00A5) since reset; only_dirty=1.
  → exactly 8 bytes: EF,BE,AD,DE,A5,00,00,00; words_sent=2.
- i_start pulsed again mid-run at word 10.
  → no restart; addresses continue 11,12…; single done pulse; words_sent=128.
- Assert i_reset while in WAIT_TX of word 5 byte 2.
  → outputs 0 immediately (asynchronous, before next clock edge); no further tx_start; fresh start dumps from address 0.
- MEM_LATENCY=3, stalled tx (done after 50 cycles).
  → sampled data is the word at the current address, never the previous address; selects never drop during the run.
- N_WORDS=1.
  → 4 bytes from address 0, then done; address output never exceeds 0.
